// File: rtl/mgmt_cmd_sequencer_if.sv
// rtl/mgmt_cmd_sequencer_if.sv - script load, control and command/response bundle for mgmt_cmd_sequencer
// master = host/test controller side, slave = sequencer side.
interface mgmt_cmd_sequencer_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [31:0]   wr_cc;
  logic [32:0]   wr_param;
  logic [31:0]   wr_exp_rc;
  logic          clear;
  logic          go;
  logic          abort;
  logic [31:0]   tpm_rc;
  logic [31:0]   tpm_cc;
  logic [32:0]   cmd_param;
  logic          keyStart_n;
  logic          busy;
  logic          done;
  logic          full;
  logic [AW:0]   entry_count;
  logic [AW:0]   pass_count;
  logic [AW:0]   fail_count;
  logic [AW-1:0] first_fail_idx;
  logic [31:0]   last_rc;

  modport master (
    output wr_en, wr_cc, wr_param, wr_exp_rc, clear, go, abort, tpm_rc,
    input  tpm_cc, cmd_param, keyStart_n, busy, done, full,
           entry_count, pass_count, fail_count, first_fail_idx, last_rc
  );

  modport slave (
    input  wr_en, wr_cc, wr_param, wr_exp_rc, clear, go, abort, tpm_rc,
    output tpm_cc, cmd_param, keyStart_n, busy, done, full,
           entry_count, pass_count, fail_count, first_fail_idx, last_rc
  );
endinterface

// File: rtl/mgmt_cmd_sequencer.sv
// rtl/mgmt_cmd_sequencer.sv - scripted command replay with response checking for the management module
// Entries are issued as ISSUE(1) + WAIT(WAIT_CYCLES) + CHECK(1), so strobes are WAIT_CYCLES+2 apart.
module mgmt_cmd_sequencer #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int WAIT_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mgmt_cmd_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam int             WW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WW-1:0]  WAIT_LOAD = WW'(WAIT_CYCLES - 1);
  localparam logic [WW-1:0]  WAIT_ONE  = WW'(1);
  localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]    CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  IDX_ONE   = AW'(1);

  state_t        state, next_state;
  logic [31:0]   cc_mem    [DEPTH];
  logic [32:0]   param_mem [DEPTH];
  logic [31:0]   exp_mem   [DEPTH];
  logic [AW-1:0] idx;
  logic [WW-1:0] wait_cnt;
  logic [AW:0]   entry_count, pass_count, fail_count;
  logic [AW-1:0] first_fail_idx;
  logic [31:0]   tpm_cc, last_rc;
  logic [32:0]   cmd_param;
  logic          key_start_n, busy, done;
  logic          idle_or_done, in_run, full, do_wr, last_entry, rc_match, wait_over;

  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
  assign in_run       = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
  assign full         = (entry_count == CNT_DEPTH);
  assign do_wr        = !bus.clear && !bus.abort && !bus.go && bus.wr_en && idle_or_done && !full;
  assign last_entry   = ({1'b0, idx} == (entry_count - CNT_ONE));
  assign rc_match     = (bus.tpm_rc == exp_mem[idx]);
  assign wait_over    = (wait_cnt == '0);

  // Script storage carries no reset; its contents are only meaningful below entry_count.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      cc_mem[entry_count[AW-1:0]]    <= bus.wr_cc;
      param_mem[entry_count[AW-1:0]] <= bus.wr_param;
      exp_mem[entry_count[AW-1:0]]   <= bus.wr_exp_rc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (bus.clear) begin
      next_state = S_IDLE;
    end else if (bus.abort) begin
      if (in_run) next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (bus.go) next_state = (entry_count != '0) ? S_ISSUE : S_DONE;
        S_ISSUE:        next_state = S_WAIT;
        S_WAIT:         if (wait_over) next_state = S_CHECK;
        S_CHECK:        next_state = last_entry ? S_DONE : S_ISSUE;
        default:        next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    key_start_n = (state != S_ISSUE);
    busy        = in_run;
    done        = (state == S_DONE);
  end

  // Abort suppresses every datapath update, which is what drops an in-flight CHECK.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      entry_count    <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      idx            <= '0;
      wait_cnt       <= '0;
      tpm_cc         <= '0;
      cmd_param      <= '0;
      last_rc        <= '0;
    end else if (bus.clear) begin
      entry_count    <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else if (!bus.abort) begin
      if (do_wr) entry_count <= entry_count + CNT_ONE;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.go) begin
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            idx            <= '0;
            if (entry_count != '0) begin
              tpm_cc    <= cc_mem[0];
              cmd_param <= param_mem[0];
            end
          end
        end
        S_ISSUE: wait_cnt <= WAIT_LOAD;
        S_WAIT:  if (!wait_over) wait_cnt <= wait_cnt - WAIT_ONE;
        S_CHECK: begin
          last_rc <= bus.tpm_rc;
          if (rc_match) begin
            pass_count <= pass_count + CNT_ONE;
          end else begin
            fail_count <= fail_count + CNT_ONE;
            if (fail_count == '0) first_fail_idx <= idx;
          end
          if (!last_entry) begin
            idx       <= idx + IDX_ONE;
            tpm_cc    <= cc_mem[idx + IDX_ONE];
            cmd_param <= param_mem[idx + IDX_ONE];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tpm_cc         = tpm_cc;
  assign bus.cmd_param      = cmd_param;
  assign bus.keyStart_n     = key_start_n;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.full           = full;
  assign bus.entry_count    = entry_count;
  assign bus.pass_count     = pass_count;
  assign bus.fail_count     = fail_count;
  assign bus.first_fail_idx = first_fail_idx;
  assign bus.last_rc        = last_rc;
endmodule

// File: tb/tb_mgmt_cmd_sequencer.sv
// tb/tb_mgmt_cmd_sequencer.sv - directed self-checking bench for mgmt_cmd_sequencer
// An rc stub answers each strobe with the next value from rc_tab and logs the strobe cycle.
module tb_mgmt_cmd_sequencer;
  localparam int AW = 3, DEPTH = 8, WAITC = 16, PER = WAITC + 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mgmt_cmd_sequencer_if #(.AW(AW)) bus ();
  mgmt_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(WAITC)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] rc_tab [64];
  int          strobe_cyc [64];
  int          strobe_cnt = 0;
  int          double_low = 0;
  logic        prev_low = 1'b0;
  logic [31:0] rc_drv = 32'h0;
  assign bus.tpm_rc = rc_drv;

  always @(negedge clock) begin
    if (bus.keyStart_n === 1'b0) begin
      if (prev_low) double_low++;
      if (strobe_cnt < 64) begin
        strobe_cyc[strobe_cnt] = cyc;
        rc_drv = rc_tab[strobe_cnt];
      end
      strobe_cnt++;
      prev_low = 1'b1;
    end else begin
      prev_low = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_entry(input logic [31:0] cc, input logic [32:0] p, input logic [31:0] e);
    bus.wr_en = 1'b1; bus.wr_cc = cc; bus.wr_param = p; bus.wr_exp_rc = e;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  // g = cycle index of the edge that samples go
  task automatic pulse_go(output int g);
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    g = cyc;
  endtask

  task automatic wait_done(input int budget, output int d);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (bus.done !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_done timeout after %0d cycles, done=%b required 1", budget, bus.done);
    end
    d = cyc;
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_cc = 0; bus.wr_param = 0; bus.wr_exp_rc = 0;
    bus.clear = 0; bus.go = 0; bus.abort = 0;
    reset_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus.busy, bus.done, bus.full, bus.keyStart_n} !== 4'b0001) begin
      bad++; $display("FAIL reset_flags got=%b want=0001", {bus.busy, bus.done, bus.full, bus.keyStart_n});
    end
    total++;
    if ({bus.entry_count, bus.pass_count, bus.fail_count, bus.first_fail_idx} !== 15'h0) begin
      bad++; $display("FAIL reset_counts got=%h want=0", {bus.entry_count, bus.pass_count, bus.fail_count, bus.first_fail_idx});
    end
    total++;
    if ({bus.tpm_cc, bus.cmd_param, bus.last_rc} !== 97'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {bus.tpm_cc, bus.cmd_param, bus.last_rc});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int base, g, d;
    base = strobe_cnt;
    rc_tab[base] = 32'h0;
    write_entry(32'h144, 33'h0, 32'h0);
    pulse_go(g);
    wait_done(200, d);
    total++;
    if (strobe_cnt - base != 1) begin bad++; $display("FAIL single_strobes got=%0d want=1", strobe_cnt - base); end
    total++;
    if (strobe_cyc[base] != g) begin bad++; $display("FAIL single_strobe_time got=%0d want=%0d", strobe_cyc[base], g); end
    total++;
    if (double_low != 0) begin bad++; $display("FAIL single_strobe_width double_low=%0d want=0", double_low); end
    total++;
    if (d - g != PER) begin bad++; $display("FAIL single_done_latency got=%0d want=%0d", d - g, PER); end
    total++;
    if (bus.pass_count !== 4'd1 || bus.fail_count !== 4'd0) begin
      bad++; $display("FAIL single_counts pass=%0d fail=%0d want pass=1 fail=0", bus.pass_count, bus.fail_count);
    end
    total++;
    if (bus.tpm_cc !== 32'h144 || bus.last_rc !== 32'h0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL single_data tpm_cc=%h last_rc=%h busy=%b want 144/0/0", bus.tpm_cc, bus.last_rc, bus.busy);
    end
  endtask

  task automatic test_three();
    int base, g, d;
    do_clear();
    base = strobe_cnt;
    rc_tab[base] = 32'h000; rc_tab[base+1] = 32'h000; rc_tab[base+2] = 32'h100;
    write_entry(32'h10, 33'h1_0000_0001, 32'h000);
    write_entry(32'h11, 33'h0_0000_0002, 32'h101);
    write_entry(32'h12, 33'h1_ABCD_0003, 32'h100);
    pulse_go(g);
    wait_done(300, d);
    total++;
    if (strobe_cnt - base != 3) begin bad++; $display("FAIL three_strobes got=%0d want=3", strobe_cnt - base); end
    total++;
    if (strobe_cyc[base+1] - strobe_cyc[base] != PER || strobe_cyc[base+2] - strobe_cyc[base+1] != PER) begin
      bad++; $display("FAIL three_spacing got=%0d,%0d want=%0d", strobe_cyc[base+1] - strobe_cyc[base],
                      strobe_cyc[base+2] - strobe_cyc[base+1], PER);
    end
    total++;
    if (bus.pass_count !== 4'd2 || bus.fail_count !== 4'd1 || bus.first_fail_idx !== 3'd1) begin
      bad++; $display("FAIL three_counts pass=%0d fail=%0d ffi=%0d want 2/1/1", bus.pass_count, bus.fail_count, bus.first_fail_idx);
    end
    total++;
    if (bus.last_rc !== 32'h100 || bus.cmd_param !== 33'h1_ABCD_0003) begin
      bad++; $display("FAIL three_data last_rc=%h cmd_param=%h want 100/1abcd0003", bus.last_rc, bus.cmd_param);
    end
    total++;
    if (d - g != 3 * PER) begin bad++; $display("FAIL three_done_latency got=%0d want=%0d", d - g, 3 * PER); end
  endtask

  task automatic test_full();
    int base, g, d;
    do_clear();
    base = strobe_cnt;
    for (int i = 0; i < 9; i++) begin
      rc_tab[base+i] = 32'h0;
      write_entry(32'h200 + 32'(i), {1'b1, 32'(i)}, 32'h0);
      if (i == 6) begin
        total++;
        if (bus.full !== 1'b0) begin bad++; $display("FAIL full_early got=%b want=0", bus.full); end
      end
      if (i == 7) begin
        total++;
        if (bus.full !== 1'b1) begin bad++; $display("FAIL full_at_8 got=%b want=1", bus.full); end
      end
    end
    total++;
    if (bus.entry_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", bus.entry_count); end
    pulse_go(g);
    wait_done(400, d);
    total++;
    if (strobe_cnt - base != 8) begin bad++; $display("FAIL full_strobes got=%0d want=8", strobe_cnt - base); end
    total++;
    if (bus.pass_count !== 4'd8 || bus.tpm_cc !== 32'h207) begin
      bad++; $display("FAIL full_replay pass=%0d tpm_cc=%h want 8/207", bus.pass_count, bus.tpm_cc);
    end
    total++;
    if (d - g != 8 * PER) begin bad++; $display("FAIL full_done_latency got=%0d want=%0d", d - g, 8 * PER); end
  endtask

  task automatic test_empty_and_busy_writes();
    int base, g, d;
    do_clear();
    base = strobe_cnt;
    pulse_go(g);
    total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL empty_done done=%b busy=%b want 1/0", bus.done, bus.busy);
    end
    repeat (5) tick();
    total++;
    if (strobe_cnt != base || bus.pass_count !== 4'd0 || bus.fail_count !== 4'd0) begin
      bad++; $display("FAIL empty_quiet strobes=%0d pass=%0d fail=%0d want 0/0/0", strobe_cnt - base, bus.pass_count, bus.fail_count);
    end
    rc_tab[base] = 32'h5; rc_tab[base+1] = 32'h6;
    write_entry(32'h300, 33'h0, 32'h5);
    write_entry(32'h301, 33'h0, 32'h6);
    pulse_go(g);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) write_entry(32'hDEAD, 33'h0, 32'h0);
    total++;
    if (bus.entry_count !== 4'd2) begin bad++; $display("FAIL busy_write_count got=%0d want=2", bus.entry_count); end
    wait_done(200, d);
    total++;
    if (strobe_cnt - base != 2 || bus.pass_count !== 4'd2 || bus.entry_count !== 4'd2) begin
      bad++; $display("FAIL busy_write_replay strobes=%0d pass=%0d entries=%0d want 2/2/2",
                      strobe_cnt - base, bus.pass_count, bus.entry_count);
    end
  endtask

  task automatic test_abort();
    int base, g, d, n;
    do_clear();
    base = strobe_cnt;
    for (int i = 0; i < 6; i++) rc_tab[base+i] = 32'h0;
    for (int i = 0; i < 3; i++) write_entry(32'h400 + 32'(i), 33'h0, 32'h0);
    pulse_go(g);
    n = 0;
    while (strobe_cnt < base + 2 && n < 100) begin tick(); n++; end
    total++;
    if (strobe_cnt < base + 2) begin bad++; $display("FAIL abort_wait_strobe timeout strobes=%0d want=2", strobe_cnt - base); end
    repeat (4) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.keyStart_n !== 1'b1 || bus.done !== 1'b0) begin
      bad++; $display("FAIL abort_state busy=%b keyStart_n=%b done=%b want 0/1/0", bus.busy, bus.keyStart_n, bus.done);
    end
    total++;
    if (bus.pass_count !== 4'd1 || bus.fail_count !== 4'd0) begin
      bad++; $display("FAIL abort_counts pass=%0d fail=%0d want 1/0", bus.pass_count, bus.fail_count);
    end
    repeat (30) tick();
    total++;
    if (strobe_cnt - base != 2) begin bad++; $display("FAIL abort_quiet strobes=%0d want=2", strobe_cnt - base); end
    pulse_go(g);
    total++;
    if (bus.pass_count !== 4'd0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL rerun_clear pass=%0d busy=%b want 0/1", bus.pass_count, bus.busy);
    end
    wait_done(300, d);
    total++;
    if (strobe_cnt - base != 5 || bus.pass_count !== 4'd3 || strobe_cyc[base+2] != g) begin
      bad++; $display("FAIL rerun_result strobes=%0d pass=%0d first_strobe=%0d want 5/3/%0d",
                      strobe_cnt - base, bus.pass_count, strobe_cyc[base+2], g);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    do_clear();
    rc_tab[strobe_cnt] = 32'h0;
    write_entry(32'h5A5, 33'h1_0000_0000, 32'h0);
    write_entry(32'h5A6, 33'h0, 32'h0);
    pulse_go(g);
    repeat (5) tick();
    total++;
    if (bus.busy !== 1'b1 || bus.tpm_cc !== 32'h5A5) begin
      bad++; $display("FAIL reset_mid_pre busy=%b tpm_cc=%h want 1/5a5", bus.busy, bus.tpm_cc);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.keyStart_n !== 1'b1 || bus.done !== 1'b0 || bus.full !== 1'b0) begin
      bad++; $display("FAIL reset_mid_async busy=%b keyStart_n=%b done=%b full=%b want 0/1/0/0",
                      bus.busy, bus.keyStart_n, bus.done, bus.full);
    end
    total++;
    if ({bus.entry_count, bus.pass_count, bus.fail_count, bus.first_fail_idx} !== 15'h0 ||
        {bus.tpm_cc, bus.cmd_param, bus.last_rc} !== 97'h0) begin
      bad++; $display("FAIL reset_mid_values entries=%0d tpm_cc=%h cmd_param=%h want 0/0/0",
                      bus.entry_count, bus.tpm_cc, bus.cmd_param);
    end
    tick();
    reset_n = 1'b1;
    tick();
    total++;
    if (double_low != 0) begin bad++; $display("FAIL strobe_width_overall double_low=%0d want=0", double_low); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_full();
    test_empty_and_busy_writes();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mgmt_cmd_sequencer.md
Name: mgmt_cmd_sequencer

Overview:
- Command initiator for the management module's command interface.
- Holds a small script of {command code, parameter, expected response code} entries loaded by a host or test controller, then replays them in order.
- Each command is issued with a one-cycle active-low start strobe. After a fixed settle window, tpm_rc is sampled and compared against the expected code.
- Produces pass/fail counts and first-failure index; replaces manual switch/keypress command entry in synthesizable tests.

Parameters:
- DEPTH, 8, number of script entries (power of two).
- AW, 3, index width, log2(DEPTH).
- WAIT_CYCLES, 16, clock cycles from strobe deassertion to tpm_rc sample (>=1).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write one script entry (accepted only in IDLE or DONE).
- wr_cc  in  32  command code for entry.
- wr_param  in  33  command parameter for entry.
- wr_exp_rc  in  32  expected response code for entry.
- clear  in  1  empty script, zero counters, return to IDLE.
- go  in  1  start replay from entry 0.
- abort  in  1  stop replay, return to IDLE.
- tpm_rc  in  32  response code from management module.
- tpm_cc  out  32  command code to management module.
- cmd_param  out  33  command parameter to management module.
- keyStart_n  out  1  active-low one-cycle command strobe.
- busy  out  1  replay in progress.
- done  out  1  replay complete (level).
- full  out  1  script holds DEPTH entries.
- entry_count  out  AW+1  entries loaded.
- pass_count  out  AW+1  entries whose rc matched.
- fail_count  out  AW+1  entries whose rc mismatched.
- first_fail_idx  out  AW  index of first mismatch (valid when fail_count>0).
- last_rc  out  32  most recently sampled tpm_rc.

Behaviour:
- Reset values:
  - outputs: all counts 0, tpm_cc 0, cmd_param 0, keyStart_n 1, busy 0, done 0, full 0, first_fail_idx 0, last_rc 0.
  - internal: state IDLE, write pointer 0.
- Clock/reset: one clock; reset is asynchronous and active-low.
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- Control priority, highest first: clear, abort, go, wr_en.
- Load rules:
  - wr_en in IDLE/DONE writes the entry at entry_count, then entry_count increments.
  - When entry_count==DEPTH, full=1 and further writes are ignored.
  - wr_en in ISSUE/WAIT/CHECK is ignored.
- clear (any state):
  - next cycle: entry_count=0, counters=0, first_fail_idx=0, done=0, busy=0, keyStart_n=1, state IDLE.
  - tpm_cc/cmd_param hold their values.
- go:
  - In IDLE or DONE with entry_count>0: zero pass/fail counts and first_fail_idx, idx=0, done=0, go to ISSUE.
  - With entry_count==0: go straight to DONE, done=1, counts 0.
  - Ignored while busy.
- ISSUE (1 cycle):
  - tpm_cc/cmd_param registered from entry idx; keyStart_n=0 that cycle; busy=1.
  - Next state WAIT with the wait counter loaded.
  - tpm_cc/cmd_param stay stable until the next ISSUE.
- WAIT: keyStart_n=1; count WAIT_CYCLES cycles, then CHECK.
- CHECK (1 cycle):
  - last_rc<=tpm_rc.
  - If tpm_rc==exp_rc[idx], pass_count++. Otherwise fail_count++, and if fail_count was 0, first_fail_idx<=idx.
  - If idx==entry_count-1: go to DONE. Otherwise idx++ and return to ISSUE.
- Latency: strobe spacing per entry is exactly WAIT_CYCLES+2 cycles.
- Completion timing: done rises on the cycle after the last CHECK; for N entries, N*(WAIT_CYCLES+2) cycles after the go cycle.
- DONE: busy=0, done=1 held until go or clear; script retained for re-run.
- abort during ISSUE/WAIT/CHECK:
  - next cycle: state IDLE, keyStart_n=1, busy=0, done=0.
  - counts retain values; an in-flight CHECK is not counted.
  - abort in IDLE/DONE: no effect.
- Simultaneous go+abort: abort wins.
- Reset mid-replay: immediate return to reset values; script contents are not guaranteed.
- Invariant: keyStart_n is never low for more than one consecutive cycle.
- Counters saturate at DEPTH by construction; no wrap.

Test Plan:
- Reset, load 1 entry {cc=0x144, param=0x0_00000000, exp=0x00000000}, go; rc stub returns 0x0 -> keyStart_n low exactly 1 cycle at go+1; done at go+18; pass_count=1, fail_count=0, last_rc=0x0.
- Load 3 entries with exp rc {0x000, 0x101, 0x100}; stub returns {0x000, 0x000, 0x100} per strobe -> pass=2, fail=1, first_fail_idx=1, strobes 18 cycles apart, last_rc=0x100.
- Write 9 entries with DEPTH=8 -> full=1 after 8th; entry_count=8; 9th ignored; replay issues exactly 8 strobes.
- go with empty script -> done=1 next cycle, no strobe, counts 0; wr_en pulses while busy change nothing.
- abort asserted in WAIT of entry 1 of a 3-entry script -> IDLE next cycle, keyStart_n=1, pass_count=1, done=0; subsequent go re-runs from entry 0 with counts cleared.
- reset_n low during WAIT -> keyStart_n=1 and busy=0 asynchronously; all outputs at reset values.
